ipv4_frame_tx: RTL and testbench
================================

Name: ipv4_frame_tx

Overview:
- Serialises one fixed-format Ethernet II / IPv4 frame, 64 bytes, onto a byte-wide MAC transmit stream when the accelerator pulses START_IP_TXN.
- The frame carries a 10-bit message: a load-balancer response or an inference result.
- The IPv4 header checksum is computed internally by combinational logic.
- Sits between the accelerator core and the Ethernet MAC TX interface.

Parameters:
- FRAME_BYTES, 64, total bytes emitted per frame, including zero padding (fixed; header layout assumes 64).

Ports:
- ACLK  input  1  clock; all state updates on rising edge.
- ARESET  input  1  reset, asynchronous, active-high.
- ACCELERATOR_IP_ADDRESS  input  32  source IP.
- ACCELERATOR_MAC_ADDRESS  input  48  source MAC.
- RECIPIENT_IP_ADDRESS  input  32  destination IP.
- RECIPIENT_MAC_ADDRESS  input  48  destination MAC.
- RECIPIENT_MESSAGE  input  10  payload value.
- START_IP_TXN  input  1  one-cycle request to send.
- READY_FOR_SEND  output  1  high when idle and able to accept START_IP_TXN.
- MAC_DATA_OUT  output  8  current byte.
- MAC_DATA_READY  input  1  MAC accepts a byte this cycle.
- MAC_DATA_VALID  output  1  frame in progress.
- MAC_DATA_LAST  output  1  marks the final byte.
- MAC_DATA_TUSER  output  1  error flag; tied to 0.

Behaviour:
- Reset state (ARESET=1, asynchronous): state IDLE, READY_FOR_SEND=1, VALID=0, LAST=0, DATA_OUT=0, byte index=0.
- All outputs are registered.
- States: IDLE, SEND, DONE.
- IDLE:
  - On an edge with START_IP_TXN=1: latch all five address/message inputs; index<=0; VALID<=1; READY_FOR_SEND<=0; DATA_OUT<=0; go to SEND.
- SEND, edge with MAC_DATA_READY=1:
  - DATA_OUT<=byte[index]; LAST<=(index==63); index++.
  - If index==63, go to DONE.
- SEND, edge with MAC_DATA_READY=0:
  - DATA_OUT<=0; LAST<=0; VALID stays 1; index holds. Stalls may be any length and occur at any index.
- DONE, next edge: VALID<=0, LAST<=0, DATA_OUT<=0, READY_FOR_SEND<=1, go to IDLE. READY_FOR_SEND is still 0 in the cycle the last byte is presented.
- START_IP_TXN outside IDLE is ignored.
- Reset mid-frame aborts the frame immediately and returns all outputs to reset values.
- Frame bytes (index: content), multi-byte fields MSB first:
  - 0-5: recipient MAC.
  - 6-11: accelerator MAC.
  - 12-13: 0x08,0x00.
  - 14: 0x45.
  - 15: 0x00.
  - 16-17: total length 0x0016 (20 header + 2 data).
  - 18-19: identification 0x0000.
  - 20-21: flags/fragment 0x0000.
  - 22: TTL 0x80.
  - 23: protocol 0x04.
  - 24-25: header checksum.
  - 26-29: accelerator IP.
  - 30-33: recipient IP.
  - 34: {6'b0, msg[9:8]}.
  - 35: msg[7:0].
  - 36-63: 0x00.
- Checksum (combinational, from latched fields): sum the ten 16-bit header words with the checksum word as 0, in a ≥20-bit accumulator. Fold carries into the low 16 bits twice (end-around carry). Output the bitwise complement.
- Header words: 0x4500, 0x0016, 0x0000, 0x0000, 0x8004, srcIP[31:16], srcIP[15:0], dstIP[31:16], dstIP[15:0].

Test Plan:
1. Reset, then check idle outputs -> READY_FOR_SEND=1, VALID=0, LAST=0, TUSER=0.
2. Inputs: srcIP=0xbeefbeef, srcMAC=0x54b00bedabba, dstIP=0xdeadbeef, dstMAC=0x32dabbadebd5, msg=0x1ff; pulse START with READY=0, then hold READY=1 -> 64 consecutive bytes: 32 da bb ad eb d5 54 b0 0b ed ab ba 08 00 45 00 00 16 00 00 00 00 80 04 1f 68 be ef be ef de ad be ef 01 ff, then 28×00. LAST=1 only on byte 63; READY_FOR_SEND=0 throughout, then 1 one cycle after the last byte.
3. Same frame with READY deasserted before byte indices 4,5,6,7,20,33 for 1,2,3,4,5,6 cycles respectively -> during each stall VALID=1 and DATA_OUT=0x00; byte sequence otherwise identical with no bytes skipped or repeated.
4. Pulse START again mid-frame -> ignored; frame completes unchanged.
5. Change RECIPIENT_* inputs mid-frame -> emitted bytes reflect the values latched at START.
6. Assert ARESET mid-frame (e.g. at byte 10) -> outputs return to reset values asynchronously; a new START sends a complete frame from byte 0.

Source files
------------

// File: rtl/ipv4_frame_tx_if.sv
// rtl/ipv4_frame_tx_if.sv - accelerator request and MAC byte stream bundle for ipv4_frame_tx
interface ipv4_frame_tx_if;
    logic [31:0] ACCELERATOR_IP_ADDRESS;
    logic [47:0] ACCELERATOR_MAC_ADDRESS;
    logic [31:0] RECIPIENT_IP_ADDRESS;
    logic [47:0] RECIPIENT_MAC_ADDRESS;
    logic [9:0]  RECIPIENT_MESSAGE;
    logic        START_IP_TXN;
    logic        READY_FOR_SEND;
    logic [7:0]  MAC_DATA_OUT;
    logic        MAC_DATA_READY;
    logic        MAC_DATA_VALID;
    logic        MAC_DATA_LAST;
    logic        MAC_DATA_TUSER;

    // Frame transmitter view: takes the request, produces the byte stream.
    modport master (
        input  ACCELERATOR_IP_ADDRESS,
        input  ACCELERATOR_MAC_ADDRESS,
        input  RECIPIENT_IP_ADDRESS,
        input  RECIPIENT_MAC_ADDRESS,
        input  RECIPIENT_MESSAGE,
        input  START_IP_TXN,
        output READY_FOR_SEND,
        output MAC_DATA_OUT,
        input  MAC_DATA_READY,
        output MAC_DATA_VALID,
        output MAC_DATA_LAST,
        output MAC_DATA_TUSER
    );

    // Accelerator/MAC view: issues the request, consumes the byte stream.
    modport slave (
        output ACCELERATOR_IP_ADDRESS,
        output ACCELERATOR_MAC_ADDRESS,
        output RECIPIENT_IP_ADDRESS,
        output RECIPIENT_MAC_ADDRESS,
        output RECIPIENT_MESSAGE,
        output START_IP_TXN,
        input  READY_FOR_SEND,
        input  MAC_DATA_OUT,
        output MAC_DATA_READY,
        input  MAC_DATA_VALID,
        input  MAC_DATA_LAST,
        input  MAC_DATA_TUSER
    );
endinterface

// File: rtl/ipv4_frame_tx.sv
// rtl/ipv4_frame_tx.sv - serialises a fixed 64-byte Ethernet II / IPv4 frame onto a byte stream
module ipv4_frame_tx #(
    parameter int FRAME_BYTES = 64
) (
    input  logic             ACLK,
    input  logic             ARESET,
    ipv4_frame_tx_if.master  tx
);

    localparam logic [5:0] LAST_IDX = 6'(FRAME_BYTES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q;
    logic [5:0]  idx_q;
    logic [7:0]  data_q;
    logic        valid_q;
    logic        last_q;
    logic        rfs_q;

    logic [31:0] src_ip_q;
    logic [47:0] src_mac_q;
    logic [31:0] dst_ip_q;
    logic [47:0] dst_mac_q;
    logic [9:0]  msg_q;

    logic [7:0]  byte_d;

    // Header checksum: the constant header words plus both addresses, then
    // two end-around carry folds (the second can only add a single carry).
    logic [19:0] csum_acc;
    logic [16:0] csum_fold1;
    logic [15:0] csum_fold2;
    logic [15:0] csum;

    assign csum_acc   = 20'h04500 + 20'h00016 + 20'h00000 + 20'h00000 + 20'h08004
                      + {4'h0, src_ip_q[31:16]} + {4'h0, src_ip_q[15:0]}
                      + {4'h0, dst_ip_q[31:16]} + {4'h0, dst_ip_q[15:0]};
    assign csum_fold1 = {1'b0, csum_acc[15:0]} + {13'h0, csum_acc[19:16]};
    assign csum_fold2 = csum_fold1[15:0] + {15'h0, csum_fold1[16]};
    assign csum       = ~csum_fold2;

    // Frame byte selected by the current index from the latched fields.
    always_comb begin
        byte_d = 8'h00;
        case (idx_q)
            6'd0:  byte_d = dst_mac_q[47:40];
            6'd1:  byte_d = dst_mac_q[39:32];
            6'd2:  byte_d = dst_mac_q[31:24];
            6'd3:  byte_d = dst_mac_q[23:16];
            6'd4:  byte_d = dst_mac_q[15:8];
            6'd5:  byte_d = dst_mac_q[7:0];
            6'd6:  byte_d = src_mac_q[47:40];
            6'd7:  byte_d = src_mac_q[39:32];
            6'd8:  byte_d = src_mac_q[31:24];
            6'd9:  byte_d = src_mac_q[23:16];
            6'd10: byte_d = src_mac_q[15:8];
            6'd11: byte_d = src_mac_q[7:0];
            6'd12: byte_d = 8'h08;
            6'd13: byte_d = 8'h00;
            6'd14: byte_d = 8'h45;
            6'd15: byte_d = 8'h00;
            6'd16: byte_d = 8'h00;
            6'd17: byte_d = 8'h16;
            6'd22: byte_d = 8'h80;
            6'd23: byte_d = 8'h04;
            6'd24: byte_d = csum[15:8];
            6'd25: byte_d = csum[7:0];
            6'd26: byte_d = src_ip_q[31:24];
            6'd27: byte_d = src_ip_q[23:16];
            6'd28: byte_d = src_ip_q[15:8];
            6'd29: byte_d = src_ip_q[7:0];
            6'd30: byte_d = dst_ip_q[31:24];
            6'd31: byte_d = dst_ip_q[23:16];
            6'd32: byte_d = dst_ip_q[15:8];
            6'd33: byte_d = dst_ip_q[7:0];
            6'd34: byte_d = {6'b0, msg_q[9:8]};
            6'd35: byte_d = msg_q[7:0];
            default: byte_d = 8'h00;
        endcase
    end

    // Frame sequencer: latch on start, emit one byte per accepted cycle, then
    // spend one cycle in DONE before reopening for the next request.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state_q   <= IDLE;
            idx_q     <= 6'd0;
            data_q    <= 8'h00;
            valid_q   <= 1'b0;
            last_q    <= 1'b0;
            rfs_q     <= 1'b1;
            src_ip_q  <= 32'h0;
            src_mac_q <= 48'h0;
            dst_ip_q  <= 32'h0;
            dst_mac_q <= 48'h0;
            msg_q     <= 10'h0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (tx.START_IP_TXN) begin
                        src_ip_q  <= tx.ACCELERATOR_IP_ADDRESS;
                        src_mac_q <= tx.ACCELERATOR_MAC_ADDRESS;
                        dst_ip_q  <= tx.RECIPIENT_IP_ADDRESS;
                        dst_mac_q <= tx.RECIPIENT_MAC_ADDRESS;
                        msg_q     <= tx.RECIPIENT_MESSAGE;
                        idx_q     <= 6'd0;
                        data_q    <= 8'h00;
                        last_q    <= 1'b0;
                        valid_q   <= 1'b1;
                        rfs_q     <= 1'b0;
                        state_q   <= SEND;
                    end
                end
                SEND: begin
                    if (tx.MAC_DATA_READY) begin
                        data_q <= byte_d;
                        last_q <= (idx_q == LAST_IDX);
                        idx_q  <= idx_q + 6'd1;
                        if (idx_q == LAST_IDX) begin
                            state_q <= DONE;
                        end
                    end else begin
                        data_q <= 8'h00;
                        last_q <= 1'b0;
                    end
                end
                DONE: begin
                    data_q  <= 8'h00;
                    last_q  <= 1'b0;
                    valid_q <= 1'b0;
                    rfs_q   <= 1'b1;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign tx.READY_FOR_SEND = rfs_q;
    assign tx.MAC_DATA_OUT   = data_q;
    assign tx.MAC_DATA_VALID = valid_q;
    assign tx.MAC_DATA_LAST  = last_q;
    assign tx.MAC_DATA_TUSER = 1'b0;

endmodule

// File: tb/tb_ipv4_frame_tx.sv
// tb/tb_ipv4_frame_tx.sv - self-checking bench for ipv4_frame_tx
module tb_ipv4_frame_tx;

    logic ACLK = 1'b0;
    logic ARESET;

    ipv4_frame_tx_if bus ();

    ipv4_frame_tx dut (
        .ACLK   (ACLK),
        .ARESET (ARESET),
        .tx     (bus)
    );

    always #5 ACLK = ~ACLK;

    typedef struct {
        logic [31:0] src_ip;
        logic [47:0] src_mac;
        logic [31:0] dst_ip;
        logic [47:0] dst_mac;
        logic [9:0]  msg;
        logic [15:0] exp_csum;
        int          stall_mode;
        bit          poke_start;
        bit          change_rcpt;
    } vec_t;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0] frame [64];
    logic [7:0] obs   [64];
    int         stall [64];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Ones' complement sum of the header words, folded until no carry remains.
    function automatic logic [15:0] ref_csum(input logic [31:0] sip, input logic [31:0] dip);
        int unsigned s;
        s = 32'h4500 + 32'h0016 + 32'h8004
          + 32'(sip[31:16]) + 32'(sip[15:0]) + 32'(dip[31:16]) + 32'(dip[15:0]);
        while ((s >> 16) != 0) s = (s & 32'hffff) + (s >> 16);
        return ~s[15:0];
    endfunction

    // Expected frame assembled field by field, then padded to 64 bytes.
    task automatic build_frame(input vec_t v);
        logic [7:0]  q[$];
        logic [15:0] c;
        c = ref_csum(v.src_ip, v.dst_ip);
        q = {};
        for (int i = 5; i >= 0; i--) q.push_back(v.dst_mac[i*8 +: 8]);
        for (int i = 5; i >= 0; i--) q.push_back(v.src_mac[i*8 +: 8]);
        q.push_back(8'h08); q.push_back(8'h00);
        q.push_back(8'h45); q.push_back(8'h00);
        q.push_back(8'h00); q.push_back(8'h16);
        q.push_back(8'h00); q.push_back(8'h00);
        q.push_back(8'h00); q.push_back(8'h00);
        q.push_back(8'h80); q.push_back(8'h04);
        q.push_back(c[15:8]); q.push_back(c[7:0]);
        for (int i = 3; i >= 0; i--) q.push_back(v.src_ip[i*8 +: 8]);
        for (int i = 3; i >= 0; i--) q.push_back(v.dst_ip[i*8 +: 8]);
        q.push_back({6'b0, v.msg[9:8]});
        q.push_back(v.msg[7:0]);
        while (q.size() < 64) q.push_back(8'h00);
        for (int i = 0; i < 64; i++) frame[i] = q[i];
    endtask

    task automatic make_stalls(input int mode);
        for (int i = 0; i < 64; i++) stall[i] = 0;
        if (mode == 1) begin
            stall[4] = 1; stall[5] = 2; stall[6] = 3;
            stall[7] = 4; stall[20] = 5; stall[33] = 6;
        end else if (mode == 2) begin
            for (int i = 0; i < 64; i++)
                if ($urandom_range(0, 9) < 3) stall[i] = int'($urandom_range(1, 4));
        end
    endtask

    task automatic run_frame(input vec_t v, input string tag);
        int w;
        w = 0;
        while (bus.READY_FOR_SEND !== 1'b1 && w < 100) begin
            @(negedge ACLK);
            w++;
        end
        check({tag, " rfs_wait"}, 64'(bus.READY_FOR_SEND), 64'd1);

        build_frame(v);
        make_stalls(v.stall_mode);

        bus.ACCELERATOR_IP_ADDRESS  = v.src_ip;
        bus.ACCELERATOR_MAC_ADDRESS = v.src_mac;
        bus.RECIPIENT_IP_ADDRESS    = v.dst_ip;
        bus.RECIPIENT_MAC_ADDRESS   = v.dst_mac;
        bus.RECIPIENT_MESSAGE       = v.msg;
        bus.START_IP_TXN            = 1'b1;
        bus.MAC_DATA_READY          = 1'b0;
        @(negedge ACLK);
        bus.START_IP_TXN = 1'b0;
        check({tag, " start_valid"}, 64'(bus.MAC_DATA_VALID), 64'd1);
        check({tag, " start_data"},  64'(bus.MAC_DATA_OUT),   64'd0);
        check({tag, " start_rfs"},   64'(bus.READY_FOR_SEND), 64'd0);

        for (int k = 0; k < 64; k++) begin
            if (v.change_rcpt && k == 10) begin
                bus.RECIPIENT_IP_ADDRESS  = $urandom;
                bus.RECIPIENT_MAC_ADDRESS = {16'($urandom), $urandom};
                bus.RECIPIENT_MESSAGE     = 10'($urandom);
                bus.ACCELERATOR_IP_ADDRESS = $urandom;
            end
            for (int s = 0; s < stall[k]; s++) begin
                bus.MAC_DATA_READY = 1'b0;
                bus.START_IP_TXN   = v.poke_start && (k == 20);
                @(negedge ACLK);
                check($sformatf("%s stall%0d_valid", tag, k), 64'(bus.MAC_DATA_VALID), 64'd1);
                check($sformatf("%s stall%0d_data", tag, k),  64'(bus.MAC_DATA_OUT),   64'd0);
                check($sformatf("%s stall%0d_last", tag, k),  64'(bus.MAC_DATA_LAST),  64'd0);
            end
            bus.MAC_DATA_READY = 1'b1;
            bus.START_IP_TXN   = v.poke_start && (k == 20);
            @(negedge ACLK);
            bus.START_IP_TXN = 1'b0;
            obs[k] = bus.MAC_DATA_OUT;
            check($sformatf("%s byte%0d", tag, k), 64'(bus.MAC_DATA_OUT), 64'(frame[k]));
            check($sformatf("%s last%0d", tag, k), 64'(bus.MAC_DATA_LAST), 64'(k == 63));
            check($sformatf("%s valid%0d", tag, k), 64'(bus.MAC_DATA_VALID), 64'd1);
            check($sformatf("%s rfs%0d", tag, k), 64'(bus.READY_FOR_SEND), 64'd0);
        end
        check({tag, " csum"}, 64'({obs[24], obs[25]}), 64'(v.exp_csum));

        bus.MAC_DATA_READY = 1'($urandom);
        @(negedge ACLK);
        check({tag, " end_valid"}, 64'(bus.MAC_DATA_VALID), 64'd0);
        check({tag, " end_last"},  64'(bus.MAC_DATA_LAST),  64'd0);
        check({tag, " end_data"},  64'(bus.MAC_DATA_OUT),   64'd0);
        check({tag, " end_rfs"},   64'(bus.READY_FOR_SEND), 64'd1);
        check({tag, " end_tuser"}, 64'(bus.MAC_DATA_TUSER), 64'd0);
    endtask

    vec_t tbl [7];
    vec_t rv;

    initial begin
        tbl[0] = '{32'hbeefbeef, 48'h54b00bedabba, 32'hdeadbeef, 48'h32dabbadebd5, 10'h1ff, 16'h1f68, 0, 1'b0, 1'b0};
        tbl[1] = '{32'hbeefbeef, 48'h54b00bedabba, 32'hdeadbeef, 48'h32dabbadebd5, 10'h1ff, 16'h1f68, 1, 1'b0, 1'b0};
        tbl[2] = '{32'hbeefbeef, 48'h54b00bedabba, 32'hdeadbeef, 48'h32dabbadebd5, 10'h1ff, 16'h1f68, 2, 1'b1, 1'b0};
        tbl[3] = '{32'hbeefbeef, 48'h54b00bedabba, 32'hdeadbeef, 48'h32dabbadebd5, 10'h1ff, 16'h1f68, 2, 1'b0, 1'b1};
        tbl[4] = '{32'h00000000, 48'h000000000000, 32'h00000000, 48'h000000000000, 10'h000, 16'h3ae5, 0, 1'b0, 1'b0};
        tbl[5] = '{32'hffffffff, 48'hffffffffffff, 32'hffffffff, 48'hffffffffffff, 10'h3ff, 16'h3ae5, 2, 1'b0, 1'b0};
        tbl[6] = '{32'hc0a80001, 48'h020000000001, 32'hc0a800c7, 48'h02000000abcd, 10'h2a5, 16'hb8cb, 1, 1'b0, 1'b0};

        ARESET = 1'b1;
        bus.ACCELERATOR_IP_ADDRESS  = 32'h0;
        bus.ACCELERATOR_MAC_ADDRESS = 48'h0;
        bus.RECIPIENT_IP_ADDRESS    = 32'h0;
        bus.RECIPIENT_MAC_ADDRESS   = 48'h0;
        bus.RECIPIENT_MESSAGE       = 10'h0;
        bus.START_IP_TXN            = 1'b0;
        bus.MAC_DATA_READY          = 1'b0;
        repeat (3) @(negedge ACLK);
        check("reset_rfs",   64'(bus.READY_FOR_SEND), 64'd1);
        check("reset_valid", 64'(bus.MAC_DATA_VALID), 64'd0);
        check("reset_last",  64'(bus.MAC_DATA_LAST),  64'd0);
        check("reset_data",  64'(bus.MAC_DATA_OUT),   64'd0);
        check("reset_tuser", 64'(bus.MAC_DATA_TUSER), 64'd0);
        ARESET = 1'b0;
        @(negedge ACLK);
        check("idle_rfs",   64'(bus.READY_FOR_SEND), 64'd1);
        check("idle_valid", 64'(bus.MAC_DATA_VALID), 64'd0);

        for (int i = 0; i < 7; i++) run_frame(tbl[i], $sformatf("vec%0d", i));

        // Reset in the middle of a frame, then a complete fresh frame.
        build_frame(tbl[0]);
        bus.ACCELERATOR_IP_ADDRESS  = tbl[0].src_ip;
        bus.ACCELERATOR_MAC_ADDRESS = tbl[0].src_mac;
        bus.RECIPIENT_IP_ADDRESS    = tbl[0].dst_ip;
        bus.RECIPIENT_MAC_ADDRESS   = tbl[0].dst_mac;
        bus.RECIPIENT_MESSAGE       = tbl[0].msg;
        bus.START_IP_TXN = 1'b1;
        @(negedge ACLK);
        bus.START_IP_TXN = 1'b0;
        bus.MAC_DATA_READY = 1'b1;
        for (int k = 0; k < 10; k++) @(negedge ACLK);
        check("rst_pre_byte9", 64'(bus.MAC_DATA_OUT), 64'(frame[9]));
        #2;
        ARESET = 1'b1;
        #1;
        check("rst_async_rfs",   64'(bus.READY_FOR_SEND), 64'd1);
        check("rst_async_valid", 64'(bus.MAC_DATA_VALID), 64'd0);
        check("rst_async_last",  64'(bus.MAC_DATA_LAST),  64'd0);
        check("rst_async_data",  64'(bus.MAC_DATA_OUT),   64'd0);
        @(negedge ACLK);
        ARESET = 1'b0;
        bus.MAC_DATA_READY = 1'b0;
        @(negedge ACLK);
        check("rst_after_valid", 64'(bus.MAC_DATA_VALID), 64'd0);
        run_frame(tbl[0], "post_rst");

        for (int n = 0; n < 6; n++) begin
            rv.src_ip      = $urandom;
            rv.src_mac     = {16'($urandom), $urandom};
            rv.dst_ip      = $urandom;
            rv.dst_mac     = {16'($urandom), $urandom};
            rv.msg         = 10'($urandom);
            rv.exp_csum    = ref_csum(rv.src_ip, rv.dst_ip);
            rv.stall_mode  = 2;
            rv.poke_start  = 1'($urandom);
            rv.change_rcpt = 1'($urandom);
            run_frame(rv, $sformatf("rnd%0d", n));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
